// File: rtl/renkon_serial_out_pkg.sv
// Shared parameters and types for the renkon serial output stage.
package renkon_serial_out_pkg;

  localparam int RENKON_CORE    = 8;
  localparam int RENKON_CORELOG = 3;
  localparam int DWIDTH         = 16;
  localparam int IMGSIZE        = 12;
  localparam int LWIDTH         = 10;
  localparam int VWIDTH         = RENKON_CORE * DWIDTH;

  localparam logic [RENKON_CORELOG:0] CORE_N = (RENKON_CORELOG+1)'(RENKON_CORE);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  // A zero or out-of-range channel count means "all cores".
  function automatic logic [RENKON_CORELOG:0] norm_active(input logic [RENKON_CORELOG:0] n);
    if (n == '0 || n > CORE_N) return CORE_N;
    return n;
  endfunction

endpackage

// File: rtl/renkon_serial_out_if.sv
// Pixel-vector stream in, image-memory write port out.
interface renkon_serial_out_if;
  import renkon_serial_out_pkg::*;

  logic               in_start;
  logic               in_valid;
  logic               in_stop;
  logic [VWIDTH-1:0]  in_data;
  logic               in_ready;
  logic               mem_we;
  logic [IMGSIZE-1:0] mem_addr;
  logic [DWIDTH-1:0]  mem_data;

  modport master (output in_start, in_valid, in_stop, in_data,
                  input  in_ready, mem_we, mem_addr, mem_data);
  modport slave  (input  in_start, in_valid, in_stop, in_data,
                  output in_ready, mem_we, mem_addr, mem_data);

endinterface

// File: rtl/renkon_serial_out_buf.sv
// Two-entry ping-pong store for pixel vectors plus their stream-start tag.
module renkon_serial_out_buf
  import renkon_serial_out_pkg::*;
(
  input  logic              clk,
  input  logic              xrst,
  input  logic              push,
  input  logic [VWIDTH-1:0] push_data,
  input  logic              push_start,
  input  logic              pop,
  output logic [VWIDTH-1:0] head_data,
  output logic              head_start,
  output logic [1:0]        occupancy,
  output logic              full,
  output logic              empty
);

  logic [VWIDTH-1:0] data_q [2];
  logic [1:0]        start_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Entry storage, ping-pong pointers and occupancy count.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      start_q   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      occ_q     <= 2'd0;
    end else begin
      if (push_ok) begin
        data_q[wr_ptr_q]  <= push_data;
        start_q[wr_ptr_q] <= push_start;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head_data  = data_q[rd_ptr_q];
  assign head_start = start_q[rd_ptr_q];
  assign occupancy  = occ_q;
  assign full       = (occ_q == 2'd2);
  assign empty      = (occ_q == 2'd0);

endmodule

// File: rtl/renkon_serial_out.sv
// Buffers per-pixel channel vectors and writes them one word per cycle
// into image memory at base + channel*area + pixel.
//
// state   | meaning
// S_IDLE  | waiting for req
// S_RUN   | accepting pixel vectors and serializing
// S_DRAIN | stop beat taken, emptying the buffer
// S_DONE  | one-cycle done pulse
module renkon_serial_out
  import renkon_serial_out_pkg::*;
(
  input  logic                    clk,
  input  logic                    xrst,
  input  logic                    req,
  input  logic [IMGSIZE-1:0]      output_addr,
  input  logic [IMGSIZE-1:0]      out_area,
  input  logic [LWIDTH-1:0]       chan_base,
  input  logic [RENKON_CORELOG:0] n_active,
  renkon_serial_out_if.slave      bus,
  output logic                    busy,
  output logic                    done
);

  localparam logic [RENKON_CORELOG:0] ONE_N = (RENKON_CORELOG+1)'(1);

  state_e                    state_q, state_d;
  logic [IMGSIZE-1:0]        area_q;
  logic [IMGSIZE-1:0]        row0_q;
  logic [IMGSIZE-1:0]        row_start_q;
  logic [RENKON_CORELOG:0]   n_act_q;
  logic                      start_pend_q;
  logic [RENKON_CORELOG-1:0] lane_idx_q;
  logic [IMGSIZE-1:0]        lane_off_q;
  logic                      we_q;
  logic [IMGSIZE-1:0]        addr_q;
  logic [DWIDTH-1:0]         wdata_q;

  logic                      start_req;
  logic                      accept;
  logic [IMGSIZE-1:0]        row0_d;
  logic [IMGSIZE-1:0]        row_cur;
  logic                      ser_active;
  logic                      last_lane;
  logic [VWIDTH-1:0]         head_data;
  logic                      head_start;
  logic [1:0]                buf_occ;
  logic                      buf_full;
  logic                      buf_empty;

  assign start_req    = (state_q == S_IDLE) && req;
  assign bus.in_ready = (state_q == S_RUN) && !buf_full;
  assign accept       = bus.in_valid && bus.in_ready;
  // The only multiply: row of channel chan_base at pixel 0, taken once per pass.
  assign row0_d       = output_addr + IMGSIZE'(chan_base) * out_area;

  renkon_serial_out_buf u_buf (
    .clk        (clk),
    .xrst       (xrst),
    .push       (accept),
    .push_data  (bus.in_data),
    .push_start (bus.in_start || start_pend_q),
    .pop        (last_lane),
    .head_data  (head_data),
    .head_start (head_start),
    .occupancy  (buf_occ),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  // A start-tagged entry restarts the pixel count at its own row.
  assign row_cur    = head_start ? row0_q : row_start_q;
  assign ser_active = !buf_empty;
  assign last_lane  = ser_active && ({1'b0, lane_idx_q} == (n_act_q - ONE_N));

  // State register.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_RUN;
      S_RUN:   if (accept && bus.in_stop) state_d = S_DRAIN;
      S_DRAIN: if (buf_occ == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pass configuration, captured on an accepted req.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      area_q  <= '0;
      row0_q  <= '0;
      n_act_q <= '0;
    end else if (start_req) begin
      area_q  <= out_area;
      row0_q  <= row0_d;
      n_act_q <= norm_active(n_active);
    end
  end

  // Remembers an in_start that arrived without a beat, tagging the next beat.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst)                  start_pend_q <= 1'b0;
    else if (start_req)         start_pend_q <= 1'b0;
    else if (state_q == S_RUN) begin
      if (accept)               start_pend_q <= 1'b0;
      else if (bus.in_start)    start_pend_q <= 1'b1;
    end
  end

  // Serializer: one lane per cycle, address advanced by area per lane and by
  // one word per pixel (row_start holds base + pixel).
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lane_idx_q  <= '0;
      lane_off_q  <= '0;
      row_start_q <= '0;
    end else begin
      we_q <= ser_active;
      if (start_req) begin
        row_start_q <= row0_d;
        lane_idx_q  <= '0;
        lane_off_q  <= '0;
      end else if (ser_active) begin
        addr_q  <= row_cur + lane_off_q;
        wdata_q <= head_data[lane_idx_q*DWIDTH +: DWIDTH];
        if (last_lane) begin
          lane_idx_q  <= '0;
          lane_off_q  <= '0;
          row_start_q <= row_cur + IMGSIZE'(1);
        end else begin
          lane_idx_q <= lane_idx_q + RENKON_CORELOG'(1);
          lane_off_q <= lane_off_q + area_q;
        end
      end
    end
  end

  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = wdata_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_renkon_serial_out.sv
// Directed bench for renkon_serial_out: stream pixel vectors, record every
// memory write and compare against hand-computed addresses and data.
module tb_renkon_serial_out;
  import renkon_serial_out_pkg::*;

  logic                    clk = 1'b0;
  logic                    xrst = 1'b0;
  logic                    req = 1'b0;
  logic [IMGSIZE-1:0]      output_addr = '0;
  logic [IMGSIZE-1:0]      out_area = '0;
  logic [LWIDTH-1:0]       chan_base = '0;
  logic [RENKON_CORELOG:0] n_active = '0;
  logic                    busy;
  logic                    done;

  renkon_serial_out_if bus();

  renkon_serial_out dut (
    .clk         (clk),
    .xrst        (xrst),
    .req         (req),
    .output_addr (output_addr),
    .out_area    (out_area),
    .chan_base   (chan_base),
    .n_active    (n_active),
    .bus         (bus),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int wq_addr[$];
  int wq_data[$];
  int wq_cyc[$];

  // Write monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (xrst && bus.mem_we) begin
      wq_addr.push_back(int'(bus.mem_addr));
      wq_data.push_back(int'(bus.mem_data));
      wq_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VWIDTH-1:0] mk_vec(input int base, input int step);
    logic [VWIDTH-1:0] v;
    int                s;
    v = '0;
    for (int k = 0; k < RENKON_CORE; k++) begin
      s = base + step * k;
      v[k*DWIDTH +: DWIDTH] = s[15:0];
    end
    return v;
  endfunction

  function automatic int w16(input int v);
    logic [15:0] t;
    t = v[15:0];
    return int'({16'b0, t});
  endfunction

  task automatic clear_q;
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic start_pass(input int oa, input int area, input int cb, input int na);
    output_addr = oa[IMGSIZE-1:0];
    out_area    = area[IMGSIZE-1:0];
    chan_base   = cb[LWIDTH-1:0];
    n_active    = na[RENKON_CORELOG:0];
    req = 1'b1;
    tick;
    req = 1'b0;
  endtask

  task automatic send_beat(input logic [VWIDTH-1:0] d, input logic st, input logic sp,
                           output int stalls);
    bus.in_data  = d;
    bus.in_start = st;
    bus.in_stop  = sp;
    bus.in_valid = 1'b1;
    stalls = 0;
    while (!bus.in_ready && stalls < 40) begin
      tick;
      stalls++;
    end
    if (!bus.in_ready) chk_eq("ready_timeout", {31'b0, bus.in_ready}, 1);
    tick;
    bus.in_valid = 1'b0;
    bus.in_start = 1'b0;
    bus.in_stop  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < 200 && seen == 0; i++) begin
      tick;
      if (done) seen = 1;
    end
    chk_eq(tag, seen, 1);
    tick;
  endtask

  initial begin
    int st;
    int tot;
    int p;
    int k;
    int exp_a[4];
    int exp_d[4];

    bus.in_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_stop  = 1'b0;
    bus.in_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_ready", {31'b0, bus.in_ready}, 0);
    chk_eq("rst_we",    {31'b0, bus.mem_we}, 0);
    chk_eq("rst_addr",  {20'b0, bus.mem_addr}, 0);
    chk_eq("rst_data",  {16'b0, bus.mem_data}, 0);
    chk_eq("rst_busy",  {31'b0, busy}, 0);
    chk_eq("rst_done",  {31'b0, done}, 0);
    @(negedge clk);
    xrst = 1'b1;
    tick;

    // Basic single pixel, cycle-exact
    start_pass(3000, 64, 0, 8);
    chk_eq("basic_busy",  {31'b0, busy}, 1);
    chk_eq("basic_ready", {31'b0, bus.in_ready}, 1);
    bus.in_start = 1'b1;
    tick;
    bus.in_start = 1'b0;
    send_beat(mk_vec(1, 1), 1'b0, 1'b1, st);
    chk_eq("basic_lat_we", {31'b0, bus.mem_we}, 0);
    for (int i = 0; i < 8; i++) begin
      tick;
      chk_eq($sformatf("basic_we%0d", i),   {31'b0, bus.mem_we}, 1);
      chk_eq($sformatf("basic_addr%0d", i), {20'b0, bus.mem_addr}, 3000 + 64 * i);
      chk_eq($sformatf("basic_data%0d", i), {16'b0, bus.mem_data}, i + 1);
    end
    tick;
    chk_eq("basic_we_end", {31'b0, bus.mem_we}, 0);
    chk_eq("basic_done",   {31'b0, done}, 1);
    chk_eq("basic_busy_done", {31'b0, busy}, 1);
    tick;
    chk_eq("basic_done_clr", {31'b0, done}, 0);
    chk_eq("basic_idle",     {31'b0, busy}, 0);

    // Back-to-back stream of 16 pixels
    clear_q();
    start_pass(3000, 64, 0, 8);
    tot = 0;
    for (int i = 0; i < 16; i++) begin
      send_beat(mk_vec(i * 16, 1), i == 0, i == 15, st);
      tot += st;
    end
    chk_eq("b2b_stalls", tot, 98);
    wait_done("b2b_done");
    chk_eq("b2b_count", wq_addr.size(), 128);
    if (wq_addr.size() == 128) begin
      chk_eq("b2b_span", wq_cyc[127] - wq_cyc[0], 127);
      chk_eq("b2b_last_addr", wq_addr[127], 3463);
      for (int i = 0; i < 128; i++) begin
        p = i / 8;
        k = i % 8;
        chk_eq($sformatf("b2b_addr%0d", i), wq_addr[i], 3000 + 64 * k + p);
        chk_eq($sformatf("b2b_data%0d", i), wq_data[i], 16 * p + k);
      end
    end

    // Partial group, n_active=2, signed data
    clear_q();
    start_pass(100, 10, 2, 2);
    send_beat(mk_vec(-5, 3), 1'b1, 1'b0, st);
    send_beat(mk_vec(7, -2), 1'b0, 1'b1, st);
    wait_done("part2_done");
    exp_a = '{120, 130, 121, 131};
    exp_d = '{w16(-5), w16(-2), w16(7), w16(5)};
    chk_eq("part2_count", wq_addr.size(), 4);
    if (wq_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk_eq($sformatf("part2_addr%0d", i), wq_addr[i], exp_a[i]);
        chk_eq($sformatf("part2_data%0d", i), wq_data[i], exp_d[i]);
      end
    end

    // n_active=0 means all eight lanes
    clear_q();
    start_pass(0, 16, 0, 0);
    send_beat(mk_vec(50, 1), 1'b1, 1'b1, st);
    wait_done("part0_done");
    chk_eq("part0_count", wq_addr.size(), 8);
    if (wq_addr.size() == 8) begin
      chk_eq("part0_last_addr", wq_addr[7], 112);
      chk_eq("part0_last_data", wq_data[7], 57);
    end

    // Address wrap
    clear_q();
    start_pass(4000, 64, 1, 2);
    send_beat(mk_vec(9, 1), 1'b1, 1'b1, st);
    wait_done("wrap_done");
    chk_eq("wrap_count", wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      chk_eq("wrap_addr0", wq_addr[0], 4064);
      chk_eq("wrap_addr1", wq_addr[1], 32);
      chk_eq("wrap_data1", wq_data[1], 10);
    end

    // Protocol corners: valid while not ready, req during RUN
    clear_q();
    start_pass(3000, 64, 0, 8);
    send_beat(mk_vec(200, 1), 1'b1, 1'b0, st);
    send_beat(mk_vec(300, 1), 1'b0, 1'b0, st);
    chk_eq("corner_ready_low", {31'b0, bus.in_ready}, 0);
    bus.in_data  = mk_vec(999, 1);
    bus.in_valid = 1'b1;
    output_addr  = '0;
    n_active     = 4'd1;
    req = 1'b1;
    tick;
    req = 1'b0;
    tick;
    bus.in_valid = 1'b0;
    send_beat(mk_vec(400, 1), 1'b0, 1'b1, st);
    wait_done("corner_done");
    chk_eq("corner_count", wq_addr.size(), 24);
    if (wq_addr.size() == 24) begin
      chk_eq("corner_b_addr", wq_addr[8], 3001);
      chk_eq("corner_c_addr", wq_addr[16], 3002);
      chk_eq("corner_c_data", wq_data[16], 400);
      chk_eq("corner_last_addr", wq_addr[23], 3450);
    end

    // Reset mid-RUN with a full buffer
    clear_q();
    start_pass(3000, 64, 0, 8);
    send_beat(mk_vec(500, 1), 1'b1, 1'b0, st);
    send_beat(mk_vec(600, 1), 1'b0, 1'b0, st);
    chk_eq("rst_pre_we", {31'b0, bus.mem_we}, 1);
    #2;
    xrst = 1'b0;
    #1;
    chk_eq("rstm_we",    {31'b0, bus.mem_we}, 0);
    chk_eq("rstm_ready", {31'b0, bus.in_ready}, 0);
    chk_eq("rstm_busy",  {31'b0, busy}, 0);
    chk_eq("rstm_addr",  {20'b0, bus.mem_addr}, 0);
    chk_eq("rstm_data",  {16'b0, bus.mem_data}, 0);
    @(negedge clk);
    xrst = 1'b1;
    tick;
    clear_q();
    repeat (4) tick;
    chk_eq("rstm_no_writes", wq_addr.size(), 0);
    start_pass(3000, 64, 0, 8);
    send_beat(mk_vec(1, 1), 1'b0, 1'b1, st);
    wait_done("rstm_done");
    chk_eq("rstm_count", wq_addr.size(), 8);
    if (wq_addr.size() == 8) begin
      chk_eq("rstm_addr0", wq_addr[0], 3000);
      chk_eq("rstm_data0", wq_data[0], 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
